// File: rtl/qkv_sched_pkg.sv
// Shared types for the Q/K/V attention sequencer: state encoding (which is
// also the externally visible phase code) and default memory depths.
package qkv_sched_pkg;

  localparam int DEF_IN_DEPTH = 32;
  localparam int DEF_W_DEPTH  = 1024;
  localparam int DEF_WD_LIMIT = 65535;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_IN = 3'd1,
    S_LOAD_W  = 3'd2,
    S_PROJ    = 3'd3,
    S_ATTN_GO = 3'd4,
    S_ATTN    = 3'd5,
    S_DONE    = 3'd6,
    S_ERR     = 3'd7
  } sched_state_e;

endpackage

// File: rtl/qkv_attn_sched_watchdog.sv
// Loadable up-counter for the sequencer's wait states. o_expired flags the
// cycle on which the count would reach LIMIT, so the owner leaves on that edge.
module sched_watchdog #(
  parameter int LIMIT = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_count && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = i_count && (r_cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/qkv_attn_sched.sv
// Run sequencer: host load of input/weight memories, projection, attention.
// Optional watchdog on the PROJ/ATTN waits is built when SCHED_WATCHDOG_EN is defined.
// Handshake: a load beat transfers on a cycle where host_valid & host_ready are
// both high; host_valid may rise without waiting for ready and ready never
// depends on valid.
module qkv_attn_sched
  import qkv_sched_pkg::*;
#(
  parameter int IN_DEPTH = DEF_IN_DEPTH,
  parameter int W_DEPTH  = DEF_W_DEPTH,
  parameter int WD_LIMIT = DEF_WD_LIMIT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        host_start,
  input  logic                        host_valid,
  output logic                        host_ready,
  output logic                        init,
  output logic [$clog2(IN_DEPTH)-1:0] init_input_addr,
  output logic                        init_input_wen,
  output logic [$clog2(W_DEPTH)-1:0]  init_w_addr,
  output logic                        init_w_wen,
  output logic                        en,
  input  logic                        finished_q,
  input  logic                        finished_k,
  input  logic                        finished_v,
  output logic                        attn_start,
  input  logic                        attn_done,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [2:0]                  phase
);

  localparam int IA = $clog2(IN_DEPTH);
  localparam int WA = $clog2(W_DEPTH);
  localparam logic [IA-1:0] IN_LAST = IA'(IN_DEPTH - 1);
  localparam logic [WA-1:0] W_LAST  = WA'(W_DEPTH - 1);

  sched_state_e  r_state;
  sched_state_e  w_next;
  logic [IA-1:0] r_in_cnt;
  logic [WA-1:0] r_w_cnt;
  logic          w_accept;
  logic          w_hs;
  logic          w_in_hs;
  logic          w_w_hs;
  logic          w_all_fin;
  logic          w_wd_expired;

  assign w_accept  = ((r_state == S_IDLE) || (r_state == S_DONE)) && host_start;
  assign w_hs      = host_valid && host_ready;
  assign w_in_hs   = w_hs && (r_state == S_LOAD_IN);
  assign w_w_hs    = w_hs && (r_state == S_LOAD_W);
  assign w_all_fin = finished_q && finished_k && finished_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // host_start is only looked at in IDLE/DONE, so it is dropped everywhere else.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (host_start) w_next = S_LOAD_IN;
      S_LOAD_IN:      if (w_in_hs && (r_in_cnt == IN_LAST)) w_next = S_LOAD_W;
      S_LOAD_W:       if (w_w_hs && (r_w_cnt == W_LAST)) w_next = S_PROJ;
      S_PROJ: begin
        if (w_all_fin)         w_next = S_ATTN_GO;
        else if (w_wd_expired) w_next = S_ERR;
      end
      S_ATTN_GO:      w_next = S_ATTN;
      S_ATTN: begin
        if (attn_done)         w_next = S_DONE;
        else if (w_wd_expired) w_next = S_ERR;
      end
      S_ERR:          w_next = S_ERR;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_in_cnt <= '0;
      r_w_cnt  <= '0;
    end else begin
      if (w_in_hs) r_in_cnt <= (r_in_cnt == IN_LAST) ? '0 : r_in_cnt + 1'b1;
      if (w_w_hs)  r_w_cnt  <= (r_w_cnt == W_LAST) ? '0 : r_w_cnt + 1'b1;
    end
  end

`ifdef SCHED_WATCHDOG_EN
  logic w_wd_clear;
  logic w_wd_count;

  assign w_wd_count = (r_state == S_PROJ) || (r_state == S_ATTN);
  assign w_wd_clear = (w_next != r_state) && ((w_next == S_PROJ) || (w_next == S_ATTN));

  sched_watchdog #(.LIMIT(WD_LIMIT)) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_wd_clear),
    .i_count   (w_wd_count),
    .o_expired (w_wd_expired)
  );

  assign err = (r_state == S_ERR);
`else
  logic w_unused_wd;

  assign w_wd_expired = 1'b0;
  assign w_unused_wd  = (WD_LIMIT == 0);
  assign err          = 1'b0;
`endif

  assign host_ready      = (r_state == S_LOAD_IN) || (r_state == S_LOAD_W);
  assign init            = host_ready;
  assign init_input_addr = r_in_cnt;
  assign init_w_addr     = r_w_cnt;
  // Write enables follow the handshake combinationally so the beat lands on this edge.
  assign init_input_wen  = ~w_in_hs;
  assign init_w_wen      = ~w_w_hs;
  assign en              = (r_state == S_PROJ);
  assign attn_start      = (r_state == S_ATTN_GO);
  assign busy            = (r_state == S_LOAD_IN) || (r_state == S_LOAD_W) ||
                           (r_state == S_PROJ) || (r_state == S_ATTN_GO) ||
                           (r_state == S_ATTN);
  assign done            = (r_state == S_DONE);
  assign phase           = r_state;

endmodule

// File: tb/tb_qkv_attn_sched.sv
// Self-checking bench for qkv_attn_sched with small memories (4 input rows,
// 8 weight rows); the watchdog scenario follows SCHED_WATCHDOG_EN.
module tb_qkv_attn_sched;

  localparam int IN_DEPTH = 4;
  localparam int W_DEPTH  = 8;
  localparam int WD_LIMIT = 20;
  localparam int IA       = $clog2(IN_DEPTH);
  localparam int WA       = $clog2(W_DEPTH);
  localparam int N_BEATS  = IN_DEPTH + W_DEPTH;

  logic          clk;
  logic          rst;
  logic          host_start;
  logic          host_valid;
  logic          host_ready;
  logic          init;
  logic [IA-1:0] init_input_addr;
  logic          init_input_wen;
  logic [WA-1:0] init_w_addr;
  logic          init_w_wen;
  logic          en;
  logic          finished_q;
  logic          finished_k;
  logic          finished_v;
  logic          attn_start;
  logic          attn_done;
  logic          busy;
  logic          done;
  logic          err;
  logic [2:0]    phase;

  // Scoreboard entry: {port (0 = input, 1 = weight), address}.
  logic [10:0] exp_q[$];
  logic [10:0] m_got;
  logic [10:0] m_exp;
  int n_cmp    = 0;
  int n_err    = 0;
  int n_writes = 0;

  qkv_attn_sched #(
    .IN_DEPTH (IN_DEPTH),
    .W_DEPTH  (W_DEPTH),
    .WD_LIMIT (WD_LIMIT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .host_start      (host_start),
    .host_valid      (host_valid),
    .host_ready      (host_ready),
    .init            (init),
    .init_input_addr (init_input_addr),
    .init_input_wen  (init_input_wen),
    .init_w_addr     (init_w_addr),
    .init_w_wen      (init_w_wen),
    .en              (en),
    .finished_q      (finished_q),
    .finished_k      (finished_k),
    .finished_v      (finished_v),
    .attn_start      (attn_start),
    .attn_done       (attn_done),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .phase           (phase)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: every wen-low pulse must match the next expected beat.
  always @(negedge clk) begin
    if (!rst) begin
      if (init_input_wen === 1'b0) begin
        n_cmp++;
        n_writes++;
        m_got = {1'b0, 10'(init_input_addr)};
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL in_write_unexpected: got addr %0d, none expected", init_input_addr);
        end else begin
          m_exp = exp_q.pop_front();
          if (m_got !== m_exp) begin
            n_err++;
            $display("FAIL in_write: got port/addr %0d/%0d, want %0d/%0d",
                     m_got[10], m_got[9:0], m_exp[10], m_exp[9:0]);
          end
        end
      end
      if (init_w_wen === 1'b0) begin
        n_cmp++;
        n_writes++;
        m_got = {1'b1, 10'(init_w_addr)};
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL w_write_unexpected: got addr %0d, none expected", init_w_addr);
        end else begin
          m_exp = exp_q.pop_front();
          if (m_got !== m_exp) begin
            n_err++;
            $display("FAIL w_write: got port/addr %0d/%0d, want %0d/%0d",
                     m_got[10], m_got[9:0], m_exp[10], m_exp[9:0]);
          end
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic push_beat(input int n);
    if (n < IN_DEPTH) exp_q.push_back({1'b0, 10'(n)});
    else              exp_q.push_back({1'b1, 10'(n - IN_DEPTH)});
  endtask

  task automatic start_run();
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
  endtask

  task automatic load_beats(input int first, input int count, input int gap);
    for (int n = first; n < first + count; n++) begin
      host_valid = 1'b1;
      push_beat(n);
      tick();
      host_valid = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic finish_run();
    finished_q = 1'b1;
    finished_k = 1'b1;
    finished_v = 1'b1;
    tick();
    finished_q = 1'b0;
    finished_k = 1'b0;
    finished_v = 1'b0;
    tick();
    attn_done = 1'b1;
    tick();
    attn_done = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    rst        = 1'b1;
    host_valid = 1'b1;
    tick();
    tick();
    sample();
    n_cmp++; if (phase !== 3'd0) begin n_err++; $display("FAIL reset_phase: got %0d want 0", phase); end
    n_cmp++; if ({init, en, attn_start, host_ready, busy, done, err} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 0000000", {init, en, attn_start, host_ready, busy, done, err});
    end
    n_cmp++; if ({init_input_wen, init_w_wen} !== 2'b11) begin
      n_err++; $display("FAIL reset_wen: got %b want 11", {init_input_wen, init_w_wen});
    end
    n_cmp++; if ((init_input_addr !== '0) || (init_w_addr !== '0)) begin
      n_err++; $display("FAIL reset_addr: got %0d/%0d want 0/0", init_input_addr, init_w_addr);
    end
    rst        = 1'b0;
    host_valid = 1'b0;
    tick();
  endtask

  task automatic test_nominal();
    start_run();
    sample();
    n_cmp++; if (phase !== 3'd1) begin n_err++; $display("FAIL nom_start_phase: got %0d want 1", phase); end
    n_cmp++; if ({host_ready, init, busy} !== 3'b111) begin
      n_err++; $display("FAIL nom_load_flags: got %b want 111", {host_ready, init, busy});
    end
    load_beats(0, N_BEATS, 0);
    sample();
    n_cmp++; if ({en, init, host_ready} !== 3'b100) begin
      n_err++; $display("FAIL nom_en: got en/init/ready %b want 100", {en, init, host_ready});
    end
    n_cmp++; if (phase !== 3'd3) begin n_err++; $display("FAIL nom_proj_phase: got %0d want 3", phase); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL nom_writes_left: got %0d want 0", exp_q.size()); end
    tick();
    finished_q = 1'b1;
    finished_k = 1'b1;
    finished_v = 1'b1;
    sample();
    n_cmp++; if (attn_start !== 1'b0) begin n_err++; $display("FAIL nom_early_start: got %b want 0", attn_start); end
    tick();
    sample();
    n_cmp++; if ({attn_start, phase} !== {1'b1, 3'd4}) begin
      n_err++; $display("FAIL nom_attn_go: got start/phase %b/%0d want 1/4", attn_start, phase);
    end
    finished_q = 1'b0;
    finished_k = 1'b0;
    finished_v = 1'b0;
    tick();
    sample();
    n_cmp++; if ({attn_start, phase} !== {1'b0, 3'd5}) begin
      n_err++; $display("FAIL nom_attn_wait: got start/phase %b/%0d want 0/5", attn_start, phase);
    end
    attn_done = 1'b1;
    tick();
    attn_done = 1'b0;
    sample();
    n_cmp++; if ({done, busy, phase} !== {1'b1, 1'b0, 3'd6}) begin
      n_err++; $display("FAIL nom_done: got done/busy/phase %b/%b/%0d want 1/0/6", done, busy, phase);
    end
    tick();
  endtask

  task automatic test_host_gaps();
    int w0;
    w0 = n_writes;
    start_run();
    load_beats(0, N_BEATS, 1);
    sample();
    n_cmp++; if (phase !== 3'd3) begin n_err++; $display("FAIL gap_proj_phase: got %0d want 3", phase); end
    n_cmp++; if (n_writes - w0 != N_BEATS) begin
      n_err++; $display("FAIL gap_write_count: got %0d want %0d", n_writes - w0, N_BEATS);
    end
    tick();
    finish_run();
    sample();
    n_cmp++; if ({done, phase} !== {1'b1, 3'd6}) begin
      n_err++; $display("FAIL gap_done: got done/phase %b/%0d want 1/6", done, phase);
    end
    tick();
  endtask

  task automatic test_staggered();
    int pulses;
    pulses = 0;
    start_run();
    load_beats(0, N_BEATS, 0);
    for (int c = 0; c < 20; c++) begin
      if (c == 5)  finished_q = 1'b1;
      if (c == 9)  finished_k = 1'b1;
      if (c == 14) finished_v = 1'b1;
      sample();
      if (attn_start === 1'b1) pulses++;
      n_cmp++; if (attn_start !== (c == 15)) begin
        n_err++; $display("FAIL stag_start_c%0d: got %b want %b", c, attn_start, (c == 15));
      end
      tick();
    end
    n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL stag_pulses: got %0d want 1", pulses); end
    finished_q = 1'b0;
    finished_k = 1'b0;
    finished_v = 1'b0;
    attn_done  = 1'b1;
    tick();
    attn_done = 1'b0;
    sample();
    n_cmp++; if (phase !== 3'd6) begin n_err++; $display("FAIL stag_done_phase: got %0d want 6", phase); end
    tick();
  endtask

  task automatic test_reset_mid_load();
    start_run();
    load_beats(0, IN_DEPTH + 3, 0);
    sample();
    n_cmp++; if ({phase, 10'(init_w_addr)} !== {3'd2, 10'd3}) begin
      n_err++; $display("FAIL rml_pre: got phase/waddr %0d/%0d want 2/3", phase, init_w_addr);
    end
    rst = 1'b1;
    tick();
    sample();
    n_cmp++; if (phase !== 3'd0) begin n_err++; $display("FAIL rml_phase: got %0d want 0", phase); end
    n_cmp++; if ((init_input_addr !== '0) || (init_w_addr !== '0)) begin
      n_err++; $display("FAIL rml_addr: got %0d/%0d want 0/0", init_input_addr, init_w_addr);
    end
    n_cmp++; if ({init_input_wen, init_w_wen, busy} !== 3'b110) begin
      n_err++; $display("FAIL rml_wen_busy: got %b want 110", {init_input_wen, init_w_wen, busy});
    end
    rst = 1'b0;
    tick();
    start_run();
    sample();
    n_cmp++; if ({phase, 10'(init_input_addr)} !== {3'd1, 10'd0}) begin
      n_err++; $display("FAIL rml_restart: got phase/addr %0d/%0d want 1/0", phase, init_input_addr);
    end
    load_beats(0, N_BEATS, 0);
    finish_run();
    sample();
    n_cmp++; if (phase !== 3'd6) begin n_err++; $display("FAIL rml_done_phase: got %0d want 6", phase); end
    tick();
  endtask

  task automatic test_ignored();
    start_run();
    load_beats(0, N_BEATS, 0);
    host_start = 1'b1;
    host_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sample();
      n_cmp++; if ({phase, host_ready} !== {3'd3, 1'b0}) begin
        n_err++; $display("FAIL ign_proj_c%0d: got phase/ready %0d/%b want 3/0", c, phase, host_ready);
      end
      tick();
    end
    host_start = 1'b0;
    host_valid = 1'b0;
    finished_q = 1'b1;
    finished_k = 1'b1;
    finished_v = 1'b1;
    tick();
    finished_q = 1'b0;
    finished_k = 1'b0;
    finished_v = 1'b0;
    tick();
    sample();
    n_cmp++; if (phase !== 3'd5) begin n_err++; $display("FAIL ign_attn_phase: got %0d want 5", phase); end
    host_start = 1'b1;
    attn_done  = 1'b1;
    tick();
    host_start = 1'b0;
    attn_done  = 1'b0;
    sample();
    n_cmp++; if ({done, phase} !== {1'b1, 3'd6}) begin
      n_err++; $display("FAIL ign_done: got done/phase %b/%0d want 1/6", done, phase);
    end
    tick();
    sample();
    n_cmp++; if (phase !== 3'd6) begin n_err++; $display("FAIL ign_no_restart: got %0d want 6", phase); end
    tick();
  endtask

  task automatic test_watchdog();
    start_run();
    load_beats(0, N_BEATS, 0);
`ifdef SCHED_WATCHDOG_EN
    for (int c = 0; c < 22; c++) begin
      sample();
      n_cmp++; if (phase !== ((c < WD_LIMIT) ? 3'd3 : 3'd7)) begin
        n_err++; $display("FAIL wd_phase_c%0d: got %0d want %0d", c, phase, (c < WD_LIMIT) ? 3 : 7);
      end
      tick();
    end
    sample();
    n_cmp++; if ({err, en, busy} !== 3'b100) begin
      n_err++; $display("FAIL wd_err_flags: got err/en/busy %b want 100", {err, en, busy});
    end
`else
    repeat (40) tick();
    sample();
    n_cmp++; if ({phase, err} !== {3'd3, 1'b0}) begin
      n_err++; $display("FAIL wd_off_wait: got phase/err %0d/%b want 3/0", phase, err);
    end
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sample();
    n_cmp++; if (phase !== 3'd0) begin n_err++; $display("FAIL wd_reset_phase: got %0d want 0", phase); end
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    host_start = 1'b0;
    host_valid = 1'b0;
    finished_q = 1'b0;
    finished_k = 1'b0;
    finished_v = 1'b0;
    attn_done  = 1'b0;
    test_reset();
    test_nominal();
    test_host_gaps();
    test_staggered();
    test_reset_mid_load();
    test_ignored();
    test_watchdog();
    n_cmp++; if (exp_q.size() != 0) begin
      n_err++; $display("FAIL final_writes_left: got %0d want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
